input_cond_multi: RTL and testbench

//  Parametrised N-channel input conditioner for the game front end. It replaces the ad-hoc
//  key/switch synchronisers, edge extractors and LED pulse stretchers in the top level.
//  Per channel: 2+ stage synchroniser, ce-timed debounce, press/release pulses, optional

---
 rtl/input_cond_multi.sv | 169 ++++++++++++++++
 tb/tb_input_cond_multi.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_cond_multi.sv
// input_cond_multi: per-channel synchroniser, ce-timed debounce, press/release
// pulses, hold-to-repeat actions and LED visibility stretcher.
module input_cond_multi #(
    parameter int unsigned     N_CH          = 4,
    parameter int unsigned     SYNC_STAGES   = 2,
    parameter int unsigned     DEBOUNCE_TK   = 20,
    parameter logic [N_CH-1:0] REPEAT_MASK   = N_CH'(4'b0110),
    parameter int unsigned     REPEAT_DELAY  = 250,
    parameter int unsigned     REPEAT_PERIOD = 80,
    parameter int unsigned     STRETCH_CYC   = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] act_pulse,
    output logic [N_CH-1:0] vis
);

    localparam int unsigned RMAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW = $clog2(DEBOUNCE_TK + 1);
    localparam int RW = $clog2(RMAX + 1);
    localparam int SW = $clog2(STRETCH_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } rep_state_t;

    logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
    logic [N_CH-1:0]                  w_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DW-1:0] r_dcnt;
        logic          r_level;
        logic          r_level_d;
        logic          r_press;
        logic          r_release;
        rep_state_t    r_state;
        rep_state_t    w_state_nx;
        logic [RW-1:0] r_rcnt;
        logic [RW-1:0] w_rcnt_nx;
        logic          r_rep;
        logic          w_rep_nx;
        logic          w_act;
        logic [SW-1:0] r_scnt;

        // Any cycle where the synchronised input agrees with level restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dcnt  <= '0;
                r_level <= 1'b0;
            end else if (w_sync[g] == r_level) begin
                r_dcnt <= '0;
            end else if (ce) begin
                if (r_dcnt == DW'(DEBOUNCE_TK - 1)) begin
                    r_level <= ~r_level;
                    r_dcnt  <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DW'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_level_d <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_level_d <= r_level;
                r_press   <= r_level & ~r_level_d;
                r_release <= ~r_level & r_level_d;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_rcnt  <= '0;
                r_rep   <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_rcnt  <= w_rcnt_nx;
                r_rep   <= w_rep_nx;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_rcnt_nx  = r_rcnt;
            w_rep_nx   = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_press && REPEAT_MASK[g]) begin
                        w_state_nx = S_DELAY;
                        w_rcnt_nx  = '0;
                    end
                end
                S_DELAY: begin
                    if (!r_level) begin
                        w_state_nx = S_IDLE;
                        w_rcnt_nx  = '0;
                    end else if (ce) begin
                        if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
                            w_state_nx = S_REPEAT;
                            w_rcnt_nx  = '0;
                            w_rep_nx   = 1'b1;
                        end else begin
                            w_rcnt_nx = r_rcnt + RW'(1);
                        end
                    end
                end
                S_REPEAT: begin
                    if (!r_level) begin
                        w_state_nx = S_IDLE;
                        w_rcnt_nx  = '0;
                    end else if (ce) begin
                        if (r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
                            w_rcnt_nx = '0;
                            w_rep_nx  = 1'b1;
                        end else begin
                            w_rcnt_nx = r_rcnt + RW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_rcnt_nx  = '0;
                end
            endcase
        end

        // A repeat scheduled on the same edge the level drops is discarded.
        assign w_act = r_press | (r_rep & r_level);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_scnt <= '0;
            end else if (w_act) begin
                r_scnt <= SW'(STRETCH_CYC);
            end else if (r_scnt != '0) begin
                r_scnt <= r_scnt - SW'(1);
            end
        end

        assign level[g]         = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
        assign act_pulse[g]     = w_act;
        assign vis[g]           = (r_scnt != '0);
    end

endmodule

// File: tb/tb_input_cond_multi.sv
// tb_input_cond_multi: scenario table plus directed reset/glitch sequences;
// expected events are timed from the bench's own ce schedule.
module tb_input_cond_multi;

    localparam logic [3:0] RMASK = 4'b0110;
    localparam int         STR   = 5;
    localparam int K_LR  = 0;
    localparam int K_LF  = 1;
    localparam int K_PR  = 2;
    localparam int K_RL  = 3;
    localparam int K_ACT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [3:0] raw_in;
    logic [3:0] level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] act_pulse;
    logic [3:0] vis;

    input_cond_multi #(
        .N_CH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_TK(4),
        .REPEAT_MASK(RMASK),
        .REPEAT_DELAY(3),
        .REPEAT_PERIOD(2),
        .STRETCH_CYC(STR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .raw_in(raw_in),
        .level(level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .act_pulse(act_pulse),
        .vis(vis)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int ch;
        int e;
    } ev_t;

    typedef struct {
        logic [3:0] chans;
        int         extra;
        bit         ce_cont;
        int         exp_acts;
    } vec_t;

    ev_t        sbq[$];
    ev_t        act_hist[$];
    vec_t       vecs[6];
    int         edge_n     = 0;
    int         n_err      = 0;
    int         n_checks   = 0;
    int         act_seen   = 0;
    bit         ce_mode    = 1'b0;
    logic [3:0] prev_level = '0;
    logic [3:0] prev_act   = '0;

    function automatic logic is_ce(int k);
        return ce_mode ? 1'b1 : ((k % 4) == 0);
    endfunction

    function automatic int nth_ce(int from, int n);
        int c = 0;
        for (int k = from; k < from + 4096; k++) begin
            if (is_ce(k)) begin
                c++;
                if (c == n) return k;
            end
        end
        return -1;
    endfunction

    function automatic string kname(int k);
        case (k)
            K_LR:    return "level_rise";
            K_LF:    return "level_fall";
            K_PR:    return "press_pulse";
            K_RL:    return "release_pulse";
            default: return "act_pulse";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int ch, input int e);
        ev_t v;
        v.kind = kind;
        v.ch   = ch;
        v.e    = e;
        sbq.push_back(v);
        if (kind == K_ACT) act_hist.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic observe(input int kind, input int ch);
        int idx = -1;
        foreach (sbq[i]) begin
            if (idx < 0 && sbq[i].kind == kind && sbq[i].ch == ch && sbq[i].e == edge_n)
                idx = i;
        end
        n_checks++;
        if (idx >= 0) begin
            sbq.delete(idx);
        end else begin
            n_err++;
            $display("FAIL unexpected %s ch%0d at edge %0d: got 1, required 0",
                     kname(kind), ch, edge_n);
        end
    endtask

    task automatic sample();
        bit ev;
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                if (level[c] !== prev_level[c]) observe(level[c] ? K_LR : K_LF, c);
                if (press_pulse[c]) observe(K_PR, c);
                if (release_pulse[c]) observe(K_RL, c);
                if (act_pulse[c]) begin
                    observe(K_ACT, c);
                    act_seen++;
                    chk($sformatf("act_back_to_back ch%0d", c), int'(prev_act[c]), 0);
                end
                ev = 1'b0;
                foreach (act_hist[i]) begin
                    if (act_hist[i].ch == c && act_hist[i].e + 1 <= edge_n &&
                        edge_n <= act_hist[i].e + STR)
                        ev = 1'b1;
                end
                n_checks++;
                if (vis[c] !== ev) begin
                    n_err++;
                    $display("FAIL vis ch%0d at edge %0d: got %0b, required %0b",
                             c, edge_n, vis[c], ev);
                end
            end
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].e < edge_n) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL missing %s ch%0d at edge %0d: got 0, required 1",
                             kname(sbq[i].kind), sbq[i].ch, sbq[i].e);
                    sbq.delete(i);
                end
            end
        end
        prev_level = level;
        prev_act   = act_pulse;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
        ce = is_ce(edge_n + 1);
        sample();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " level"}, int'(level), 0);
        chk({tag, " press"}, int'(press_pulse), 0);
        chk({tag, " release"}, int'(release_pulse), 0);
        chk({tag, " act"}, int'(act_pulse), 0);
        chk({tag, " vis"}, int'(vis), 0);
    endtask

    // Press the given channels now, release them 'extra' clk after acceptance.
    task automatic press_release(input logic [3:0] chans, input int extra,
                                 input bit cont, output int acts);
        int t0, tl, t1, tf, tr;
        ce_mode = cont;
        ce      = is_ce(edge_n + 1);
        t0      = edge_n;
        raw_in  = raw_in | chans;
        tl      = nth_ce(t0 + 3, 4);
        t1      = tl + extra;
        tf      = nth_ce(t1 + 3, 4);
        for (int c = 0; c < 4; c++) begin
            if (chans[c]) begin
                expect_ev(K_LR, c, tl);
                expect_ev(K_PR, c, tl + 1);
                expect_ev(K_ACT, c, tl + 1);
                expect_ev(K_LF, c, tf);
                expect_ev(K_RL, c, tf + 1);
                if (RMASK[c]) begin
                    tr = nth_ce(tl + 3, 3);
                    while (tr < tf) begin
                        expect_ev(K_ACT, c, tr);
                        tr = nth_ce(tr + 1, 2);
                    end
                end
            end
        end
        act_seen = 0;
        while (edge_n < t1) tick();
        raw_in = raw_in & ~chans;
        while (edge_n < tf + 10) tick();
        acts = act_seen;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int acts, t0, tl, tr;
        vecs[0] = '{chans: 4'b0001, extra: 0,  ce_cont: 1'b0, exp_acts: 1};
        vecs[1] = '{chans: 4'b0010, extra: 32, ce_cont: 1'b0, exp_acts: 6};
        vecs[2] = '{chans: 4'b0100, extra: 0,  ce_cont: 1'b0, exp_acts: 2};
        vecs[3] = '{chans: 4'b0100, extra: 4,  ce_cont: 1'b0, exp_acts: 2};
        vecs[4] = '{chans: 4'b1111, extra: 8,  ce_cont: 1'b0, exp_acts: 8};
        vecs[5] = '{chans: 4'b0010, extra: 4,  ce_cont: 1'b1, exp_acts: 4};

        rst    = 1'b1;
        raw_in = 4'hF;
        ce     = 1'b0;
        repeat (3) tick();
        chk_zero("reset_held");

        rst = 1'b0;
        press_release(4'hF, 8, 1'b0, acts);
        chk("held_through_reset acts", acts, 8);

        ce_mode   = 1'b0;
        ce        = is_ce(edge_n + 1);
        act_seen  = 0;
        raw_in[1] = 1'b1;
        repeat (8) tick();
        raw_in[1] = 1'b0;
        repeat (20) tick();
        chk("glitch level1", int'(level[1]), 0);
        chk("glitch acts", act_seen, 0);

        for (int i = 0; i < 6; i++) begin
            press_release(vecs[i].chans, vecs[i].extra, vecs[i].ce_cont, acts);
            chk($sformatf("vec%0d acts", i), acts, vecs[i].exp_acts);
            chk($sformatf("vec%0d level", i), int'(level), 0);
        end

        ce_mode   = 1'b0;
        ce        = is_ce(edge_n + 1);
        t0        = edge_n;
        raw_in[1] = 1'b1;
        tl        = nth_ce(t0 + 3, 4);
        expect_ev(K_LR, 1, tl);
        expect_ev(K_PR, 1, tl + 1);
        expect_ev(K_ACT, 1, tl + 1);
        tr = nth_ce(tl + 3, 3);
        expect_ev(K_ACT, 1, tr);
        while (edge_n < tr + 2) tick();
        chk("pre_reset level1", int'(level[1]), 1);
        chk("pre_reset vis1", int'(vis[1]), 1);
        rst = 1'b1;
        sbq.delete();
        act_hist.delete();
        #1;
        chk_zero("reset_mid_hold");
        repeat (3) tick();
        chk_zero("reset_mid_hold_held");
        rst = 1'b0;
        press_release(4'b0010, 0, 1'b0, acts);
        chk("post_reset fresh press acts", acts, 2);

        repeat (5) tick();
        chk("scoreboard drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
